multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_ctrl.sv | 128 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback
// with imem/dmem handshakes, halting on SYSTEM and trapping on illegal opcode or memory timeout.
module multicycle_ctrl #(
    parameter int INST_WIDTH     = 32,
    parameter int OPCODE         = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    input  logic                  imem_ack_i,
    input  logic [INST_WIDTH-1:0] instr_i,
    output logic                  ir_we_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    input  logic                  dmem_ack_i,
    input  logic                  branch_taken_i,
    output logic                  pc_we_o,
    output logic                  pc_sel_o,
    output logic                  rf_we_o,
    output logic                  alu_src_imm_o,
    output logic [1:0]            wb_sel_o,
    output logic [2:0]            state_o,
    output logic                  halted_o,
    output logic                  trap_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, TRAP} state_e;

    localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE-1:0] OP_OPIMM  = 7'b0010011;
    localparam logic [OPCODE-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE-1:0] OP_FENCE  = 7'b0001111;
    localparam logic [OPCODE-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0]        LIMIT     = 8'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [OPCODE-1:0] opc_q, opc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              unused_instr;

    assign unused_instr = ^instr_i[INST_WIDTH-1:OPCODE];

    wire is_load   = opc_q == OP_LOAD;
    wire is_store  = opc_q == OP_STORE;
    wire is_branch = opc_q == OP_BRANCH;
    wire is_fence  = opc_q == OP_FENCE;
    wire is_system = opc_q == OP_SYSTEM;
    wire is_jump   = opc_q == OP_JAL || opc_q == OP_JALR;
    wire legal     = is_load || is_store || is_branch || is_fence || is_system || is_jump ||
                     opc_q == OP_OPIMM || opc_q == OP_OP || opc_q == OP_LUI || opc_q == OP_AUIPC;
    wire imm_op    = is_load || is_store || opc_q == OP_OPIMM || opc_q == OP_JALR ||
                     opc_q == OP_LUI || opc_q == OP_AUIPC;
    wire expired   = cnt_q == LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opc_d         = opc_q;
        imem_req_o    = 1'b0;
        ir_we_o       = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = 1'b0;
        rf_we_o       = 1'b0;
        wb_sel_o      = 2'b00;
        halted_o      = 1'b0;
        trap_o        = 1'b0;
        alu_src_imm_o = imm_op && (state_q inside {DECODE, EXECUTE, MEMORY, WRITEBACK});
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    opc_d   = instr_i[OPCODE-1:0];
                    state_d = DECODE;
                end else if (expired) state_d = TRAP;
            end
            DECODE: state_d = legal ? EXECUTE : TRAP;
            EXECUTE: begin
                pc_we_o  = is_branch || is_fence;
                pc_sel_o = is_branch && branch_taken_i;
                state_d  = (is_load || is_store) ? MEMORY :
                           (is_branch || is_fence) ? FETCH :
                           is_system ? HALT : WRITEBACK;
            end
            MEMORY: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ack_i) begin
                    pc_we_o = is_store;
                    state_d = is_store ? FETCH : WRITEBACK;
                end else if (expired) state_d = TRAP;
            end
            WRITEBACK: begin
                rf_we_o  = 1'b1;
                pc_we_o  = 1'b1;
                pc_sel_o = is_jump;
                wb_sel_o = is_load ? 2'b01 : is_jump ? 2'b10 : 2'b00;
                state_d  = FETCH;
            end
            HALT: halted_o = 1'b1;
            TRAP: trap_o = 1'b1;
        endcase
        // Counter runs only while waiting in a handshake state; any transition clears it.
        cnt_d = (state_d == state_q && (state_q == FETCH || state_q == MEMORY)) ? cnt_q + 8'd1 : 8'd0;
    end

    assign state_o = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked cycle-by-cycle against a per-instruction
// trace model built from the opcode rules, wait counts and timeout limit.
module tb_multicycle_ctrl;
    localparam int T = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_ack_i = 1'b0, dmem_ack_i = 1'b0, branch_taken_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, pc_sel_o, rf_we_o;
    logic        alu_src_imm_o, halted_o, trap_o;
    logic [1:0]  wb_sel_o;
    logic [2:0]  state_o;
    int          errs = 0, checks = 0;
    bit          need_idle;
    logic [6:0]  ops [11] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111, 7'b1110011};

    always #5 clk = ~clk;

    multicycle_ctrl #(.INST_WIDTH(32), .OPCODE(7), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .instr_i(instr_i),
        .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .branch_taken_i(branch_taken_i), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o),
        .alu_src_imm_o(alu_src_imm_o), .wb_sel_o(wb_sel_o), .state_o(state_o), .halted_o(halted_o),
        .trap_o(trap_o)
    );

    wire [14:0] outs = {state_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, pc_sel_o,
                        rf_we_o, alu_src_imm_o, wb_sel_o, halted_o, trap_o};

    function automatic logic [14:0] pk(input int st, input bit ireq, irwe, dreq, dwe, pwe, psel, rwe, imm,
                                       input logic [1:0] wb, input bit h, t);
        return {3'(st), ireq, irwe, dreq, dwe, pwe, psel, rwe, imm, wb, h, t};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit ia, da, bt, input logic [31:0] ins, input logic [14:0] exp, input string tag);
        imem_ack_i = ia; dmem_ack_i = da; branch_taken_i = bt; instr_i = ins;
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_async", outs, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        need_idle = 1'b1;
    endtask

    task automatic terminal(input bit t);
        repeat (3) cyc(rb(), rb(), rb(), $urandom, pk(t ? 7 : 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, !t, t), t ? "trap_hold" : "halt_hold");
        do_reset();
    endtask

    task automatic run(input logic [31:0] ins, input int iw, input int dw, input bit bt, input bit abort);
        logic [6:0] op;
        bit ld, st, br, fe, sy, jl, legal, imm;
        op = ins[6:0];
        ld = op == 7'b0000011; st = op == 7'b0100011; br = op == 7'b1100011;
        fe = op == 7'b0001111; sy = op == 7'b1110011; jl = op inside {7'b1101111, 7'b1100111};
        legal = op inside {ops};
        imm = op inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111};
        if (need_idle) begin
            cyc(rb(), rb(), rb(), $urandom, '0, "idle");
            need_idle = 1'b0;
        end
        for (int i = 0; i < iw && i < T; i++) cyc(0, rb(), rb(), $urandom, pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
        if (iw >= T) begin terminal(1); return; end
        cyc(1, rb(), rb(), ins, pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_ack");
        cyc(rb(), rb(), rb(), $urandom, pk(2, 0, 0, 0, 0, 0, 0, 0, imm, 0, 0, 0), "decode");
        if (!legal) begin terminal(1); return; end
        cyc(rb(), rb(), bt, $urandom, pk(3, 0, 0, 0, 0, br | fe, br & bt, 0, imm, 0, 0, 0), "execute");
        if (sy) begin terminal(0); return; end
        if (br || fe) return;
        if (ld || st) begin
            for (int i = 0; i < dw && i < T; i++) begin
                cyc(rb(), 0, rb(), $urandom, pk(4, 0, 0, 1, st, 0, 0, 0, imm, 0, 0, 0), "mem_wait");
                if (abort) begin do_reset(); return; end
            end
            if (dw >= T) begin terminal(1); return; end
            cyc(rb(), 1, rb(), $urandom, pk(4, 0, 0, 1, st, st, 0, 0, imm, 0, 0, 0), "mem_ack");
            if (st) return;
        end
        cyc(rb(), rb(), rb(), $urandom, pk(5, 0, 0, 0, 0, 1, jl, 1, imm, ld ? 2'b01 : jl ? 2'b10 : 2'b00, 0, 0), "writeback");
    endtask

    initial begin
        logic [31:0] rw, ins;
        int k, iw, dw;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", outs, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        need_idle = 1'b1;
        run(32'h002081B3, 0, 0, 0, 0);
        run(32'h0000A103, 0, 3, 0, 0);
        run(32'h00208063, 0, 0, 1, 0);
        run(32'h00208063, 1, 0, 0, 0);
        run(32'h0020A023, 2, 1, 0, 0);
        run(32'h0000006F, 0, 0, 0, 0);
        run(32'h0000000F, 0, 0, 0, 0);
        run(32'h0000007F, 0, 0, 0, 0);
        run(32'h002081B3, 20, 0, 0, 0);
        run(32'h002081B3, 15, 0, 0, 0);
        run(32'h0000A103, 0, 15, 0, 0);
        run(32'h0020A023, 1, 16, 0, 0);
        run(32'h00000073, 0, 0, 0, 0);
        run(32'h0000A103, 0, 2, 0, 1);
        run(32'h002081B3, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            rw = $urandom;
            k = $urandom_range(0, 11);
            ins = (k < 11) ? {rw[31:7], ops[k]} : rw;
            iw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2);
            dw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            run(ins, iw, dw, rb(), $urandom_range(0, 15) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
